// File: rtl/mux_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_sched
//  Description : Round-robin scheduler for a 4:1 nibble mux. Drives a
//                registered, glitch-free select, captures the mux output
//                one cycle later and queues {channel, data} in an output
//                FIFO with a valid/ready handshake.
//                Optional: define MUX_RR_SCHED_STATS_EN to add grant_cnt,
//                a saturating 16-bit count of items pushed into the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_sched #(
    parameter int DEPTH = 4,
    parameter int DW    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               req,
    output logic [3:0]               req_ack,
    output logic [1:0]               sel,
    input  logic [DW-1:0]            mux_y,
    output logic [DW-1:0]            out_data,
    output logic [1:0]               out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef MUX_RR_SCHED_STATS_EN
    ,
    output logic [15:0]              grant_cnt
`endif
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

    typedef enum logic [0:0] {
        ST_ARB     = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_sel;
    logic [1:0]      w_sel_nxt;
    logic [1:0]      r_last_gnt;
    logic [1:0]      w_last_gnt_nxt;
    logic [3:0]      r_req_ack;
    logic [3:0]      w_req_ack_nxt;
    logic [1:0]      w_winner;
    logic [1:0]      w_idx;
    logic            w_found;
    logic            w_push;
    logic            w_pop;

    logic [DW+1:0]   r_mem [DEPTH];
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_cw-1:0] r_count;

    // Round-robin pick: first asserted request scanning upward from last_gnt+1.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_gnt;
        w_idx    = r_last_gnt;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_gnt + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Next-state and registered-output decode. FIFO space is reserved at
    // grant time, so the push in CAPTURE can never overflow.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_last_gnt_nxt = r_last_gnt;
        w_req_ack_nxt  = 4'b0000;
        w_push         = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (w_found && (r_count < c_full)) begin
                    w_state_nxt    = ST_CAPTURE;
                    w_sel_nxt      = w_winner;
                    w_last_gnt_nxt = w_winner;
                    // Ack is registered so it is high for exactly the CAPTURE cycle.
                    w_req_ack_nxt  = 4'b0001 << w_winner;
                end
            end
            ST_CAPTURE: begin
                w_push      = 1'b1;
                w_state_nxt = ST_ARB;
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // Scheduler state register; sel comes straight from a flop to stay glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ARB;
            r_sel      <= 2'b00;
            r_last_gnt <= 2'b11;
            r_req_ack  <= 4'b0000;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_req_ack  <= w_req_ack_nxt;
        end
    end

    assign w_pop = out_valid && out_ready;

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: channel tag in the top two bits, mux data below.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_sel, mux_y};
        end
    end

`ifdef MUX_RR_SCHED_STATS_EN
    logic [15:0] r_grant_cnt;

    // Saturating count of items pushed into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= 16'h0000;
        end else if (w_push && (r_grant_cnt != 16'hFFFF)) begin
            r_grant_cnt <= r_grant_cnt + 16'h0001;
        end
    end

    assign grant_cnt = r_grant_cnt;
`endif

    assign req_ack    = r_req_ack;
    assign sel        = r_sel;
    assign out_valid  = (r_count != '0);
    assign fifo_count = r_count;
    assign out_data   = r_mem[r_rptr][DW-1:0];
    assign out_ch     = r_mem[r_rptr][DW+1:DW];

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_rr_sched
//  Description : Directed self-checking bench for mux_rr_sched. Models the
//                4:1 mux and synchronous sources that advance their data on
//                the edge where their req_ack was high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_sched;

    localparam int DEPTH = 4;
    localparam int DW    = 4;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req;
    logic [3:0]    req_ack;
    logic [1:0]    sel;
    logic [DW-1:0] mux_y;
    logic [DW-1:0] out_data;
    logic [1:0]    out_ch;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    fifo_count;
`ifdef MUX_RR_SCHED_STATS_EN
    logic [15:0]   grant_cnt;
`endif

    logic [DW-1:0] src [4];
    logic [3:0]    hs;
    logic          inc_en;
    int            n_checks;
    int            n_fail;

    mux_rr_sched #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_ack    (req_ack),
        .sel        (sel),
        .mux_y      (mux_y),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count)
`ifdef MUX_RR_SCHED_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    // 4:1 nibble mux model
    assign mux_y = src[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; hs holds the channels whose handshake completed on this edge.
    task automatic tick();
        hs = req_ack;
        @(posedge clk);
        #1;
        if (inc_en && hs[2]) begin
            src[2] = src[2] + 4'd1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int            nitems;
    int            acks;
    int            last_cyc;
    logic [1:0]    exp_ch [5];
    logic [3:0]    exp_d  [5];
    logic [2:0]    exp_cnt [5];
    logic [3:0]    exp_head [5];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        inc_en    = 1'b0;
        hs        = 4'b0000;
        out_ready = 1'b1;
        src[0] = 4'h0; src[1] = 4'h0; src[2] = 4'h0; src[3] = 4'h0;
        rst_n = 1'b0;
        req   = 4'b0000;
        #2;
        chk("reset_sel",     32'(sel),        32'h0);
        chk("reset_ack",     32'(req_ack),    32'h0);
        chk("reset_valid",   32'(out_valid),  32'h0);
        chk("reset_count",   32'(fifo_count), 32'h0);
        apply_reset();

        // Single request on channel 0
        src[0] = 4'hA;
        req    = 4'b0001;
        tick();
        chk("t1_sel",        32'(sel),        32'h0);
        chk("t1_ack",        32'(req_ack),    32'h1);
        chk("t1_valid_early",32'(out_valid),  32'h0);
        tick();
        req = 4'b0000;
        chk("t1_ack_gone",   32'(req_ack),    32'h0);
        chk("t1_valid",      32'(out_valid),  32'h1);
        chk("t1_data",       32'(out_data),   32'hA);
        chk("t1_ch",         32'(out_ch),     32'h0);
        chk("t1_count",      32'(fifo_count), 32'h1);
        tick();
        chk("t1_popped",     32'(out_valid),  32'h0);

        // All four requesting: round-robin from reset is 0,1,2,3,0
        apply_reset();
        src[0] = 4'h1; src[1] = 4'h2; src[2] = 4'h3; src[3] = 4'h4;
        exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd2; exp_ch[3] = 2'd3; exp_ch[4] = 2'd0;
        exp_d[0]  = 4'h1; exp_d[1]  = 4'h2; exp_d[2]  = 4'h3; exp_d[3]  = 4'h4; exp_d[4]  = 4'h1;
        req      = 4'b1111;
        nitems   = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            tick();
            if (out_valid && nitems < 5) begin
                chk($sformatf("rr_ch%0d", nitems),   32'(out_ch),   32'(exp_ch[nitems]));
                chk($sformatf("rr_data%0d", nitems), 32'(out_data), 32'(exp_d[nitems]));
                if (nitems > 0) begin
                    chk($sformatf("rr_gap%0d", nitems), 32'(cyc - last_cyc), 32'd2);
                end
                last_cyc = cyc;
                nitems++;
            end
        end
        chk("rr_items", 32'(nitems), 32'd5);

        // Fill with out_ready low on channel 2; data 1,2,3,... per capture
        apply_reset();
        out_ready = 1'b0;
        inc_en    = 1'b1;
        src[2]    = 4'h1;
        req       = 4'b0100;
        acks      = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            tick();
            if (req_ack[2]) begin
                acks++;
            end
        end
        chk("full_acks",  32'(acks),       32'd4);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_head",  32'(out_data),   32'h1);
        chk("full_sel",   32'(sel),        32'h2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_count",  32'(fifo_count), 32'd3);
        chk("pop_noack",  32'(req_ack),    32'h0);
        tick();
        chk("resume_ack", 32'(req_ack),    32'h4);
        tick();
        chk("refill_count", 32'(fifo_count), 32'd4);
        chk("refill_head",  32'(out_data),   32'h2);

        // Continuous draining while captures land on pop cycles: order kept
        exp_cnt[0] = 3'd3; exp_cnt[1] = 3'd2; exp_cnt[2] = 3'd2; exp_cnt[3] = 3'd1; exp_cnt[4] = 3'd1;
        exp_head[0] = 4'h3; exp_head[1] = 4'h4; exp_head[2] = 4'h5; exp_head[3] = 4'h6; exp_head[4] = 4'h7;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("drain_count%0d", i), 32'(fifo_count), 32'(exp_cnt[i]));
            chk($sformatf("drain_head%0d", i),  32'(out_data),   32'(exp_head[i]));
            chk($sformatf("drain_ch%0d", i),    32'(out_ch),     32'h2);
        end
        inc_en = 1'b0;

        // Reset asserted during a CAPTURE of channel 2
        apply_reset();
        out_ready = 1'b1;
        src[2]    = 4'h9;
        req       = 4'b0100;
        tick();
        chk("rst_pre_ack", 32'(req_ack), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ack",   32'(req_ack),    32'h0);
        chk("rst_valid", 32'(out_valid),  32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_sel",   32'(sel),        32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("reserve_ack", 32'(req_ack), 32'h4);
        chk("reserve_sel", 32'(sel),     32'h2);
        tick();
        req = 4'b0000;
        chk("reserve_valid", 32'(out_valid), 32'h1);
        chk("reserve_ch",    32'(out_ch),    32'h2);
        chk("reserve_data",  32'(out_data),  32'h9);

`ifdef MUX_RR_SCHED_STATS_EN
        apply_reset();
        out_ready = 1'b1;
        src[0]    = 4'h5;
        req       = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        chk("stats_ten", 32'(grant_cnt), 32'd10);
        req = 4'b0000;
        tick();
        tick();
        force dut.r_grant_cnt = 16'hFFFE;
        #1;
        release dut.r_grant_cnt;
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        chk("stats_sat", 32'(grant_cnt), 32'hFFFF);
        req = 4'b0000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
